// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of the data-memory arbiter.
// slave = arbiter side; master = requesters plus the memory model.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          r0_req;
   logic          r1_req;
   logic          r0_we;
   logic          r1_we;
   logic [AW-1:0] r0_addr;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r0_wdata;
   logic [DW-1:0] r1_wdata;
   logic          r0_gnt;
   logic          r1_gnt;
   logic          r0_rvalid;
   logic          r1_rvalid;
   logic [DW-1:0] rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   modport slave (
      input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rdata,
      output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rdata,
      input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous-read data memory.
// One transaction at a time: IDLE -> ACCESS (-> RESP for reads) -> IDLE.
module dmem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic          r_last;
   logic          r_id;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic          r_rvalid0;
   logic          r_rvalid1;
   logic          w_any;
   logic          w_winner;

   assign w_any = bus.r0_req | bus.r1_req;

   // On a tie the requester that did not win last time gets the slot.
   always_comb begin
      w_winner = 1'b0;
      if (bus.r0_req && bus.r1_req) begin
         w_winner = ~r_last;
      end else if (bus.r1_req) begin
         w_winner = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_next = ACCESS;
         ACCESS:  w_state_next = r_we ? IDLE : RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_en = 1'b0;
      bus.mem_we = 1'b0;
      bus.r0_gnt = 1'b0;
      bus.r1_gnt = 1'b0;
      bus.busy   = (r_state != IDLE);
      if (r_state == ACCESS) begin
         bus.mem_en = 1'b1;
         bus.mem_we = r_we;
         bus.r0_gnt = ~r_id;
         bus.r1_gnt = r_id;
      end
   end

   // Captured request and read-return registers; rvalid is a one-cycle pulse after RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last    <= 1'b1;
         r_id      <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         if (r_state == IDLE && w_any) begin
            r_last  <= w_winner;
            r_id    <= w_winner;
            r_we    <= w_winner ? bus.r1_we    : bus.r0_we;
            r_addr  <= w_winner ? bus.r1_addr  : bus.r0_addr;
            r_wdata <= w_winner ? bus.r1_wdata : bus.r0_wdata;
         end
         if (r_state == RESP) begin
            r_rdata   <= bus.mem_rdata;
            r_rvalid0 <= ~r_id;
            r_rvalid1 <= r_id;
         end
      end
   end

   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.rdata     = r_rdata;
   assign bus.r0_rvalid = r_rvalid0;
   assign bus.r1_rvalid = r_rvalid1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction table plus hand-written sequences for
// continuous ties, busy-time requests and reset in the middle of a read.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] last_rdata = 32'h0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

   dmem_arbiter #(.AW(32), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous-read memory; every word starts as A500_00xx so untouched words are recognisable.
   logic [31:0] mem [0:255];
   logic [31:0] mem_rdata_q = 32'h0;
   logic        mem_loaded  = 1'b0;
   assign bus.mem_rdata = mem_rdata_q;

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
         mem_loaded <= 1'b1;
      end else if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            mem_rdata_q <= mem[bus.mem_addr[7:0]];
      end
   end

   typedef struct {
      logic        req0, req1, we0, we1;
      logic [31:0] addr0, addr1, wdata0, wdata1;
      int          win;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [0:8];

   function automatic vec_t mk(input logic q0, input logic q1, input logic w0, input logic w1,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input int win, input logic [31:0] er);
      vec_t v;
      v.req0 = q0; v.req1 = q1; v.we0 = w0; v.we1 = w1;
      v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1;
      v.win = win; v.exp_rdata = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.r0_we = 1'b0; bus.r1_we = 1'b0;
      bus.r0_addr = '0; bus.r1_addr = '0; bus.r0_wdata = '0; bus.r1_wdata = '0;
   endtask

   // Requests are dropped right after capture, which also exercises withdrawal.
   task automatic run_txn(input vec_t v, input int idx);
      logic        ewe;
      logic [31:0] eaddr;
      logic [31:0] edata;
      ewe   = (v.win == 1) ? v.we1    : v.we0;
      eaddr = (v.win == 1) ? v.addr1  : v.addr0;
      edata = (v.win == 1) ? v.wdata1 : v.wdata0;
      @(negedge clk);
      bus.r0_req = v.req0; bus.r1_req = v.req1; bus.r0_we = v.we0; bus.r1_we = v.we1;
      bus.r0_addr = v.addr0; bus.r1_addr = v.addr1; bus.r0_wdata = v.wdata0; bus.r1_wdata = v.wdata1;
      @(posedge clk); #1;
      chk($sformatf("t%0d gnt0", idx), bus.r0_gnt, v.win == 0);
      chk($sformatf("t%0d gnt1", idx), bus.r1_gnt, v.win == 1);
      chk($sformatf("t%0d mem_en", idx), bus.mem_en, 1'b1);
      chk($sformatf("t%0d mem_we", idx), bus.mem_we, ewe);
      chk($sformatf("t%0d mem_addr", idx), bus.mem_addr, eaddr);
      if (ewe) chk($sformatf("t%0d mem_wdata", idx), bus.mem_wdata, edata);
      chk($sformatf("t%0d busy_acc", idx), bus.busy, 1'b1);
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      chk($sformatf("t%0d gnt_off", idx), {bus.r0_gnt, bus.r1_gnt, bus.mem_en}, 3'b000);
      if (ewe) begin
         chk($sformatf("t%0d busy_end", idx), bus.busy, 1'b0);
         chk($sformatf("t%0d rdata_hold", idx), bus.rdata, last_rdata);
      end else begin
         chk($sformatf("t%0d busy_resp", idx), bus.busy, 1'b1);
         chk($sformatf("t%0d rvalid_early", idx), {bus.r0_rvalid, bus.r1_rvalid}, 2'b00);
         @(posedge clk); #1;
         chk($sformatf("t%0d rvalid0", idx), bus.r0_rvalid, v.win == 0);
         chk($sformatf("t%0d rvalid1", idx), bus.r1_rvalid, v.win == 1);
         chk($sformatf("t%0d rdata", idx), bus.rdata, v.exp_rdata);
         chk($sformatf("t%0d busy_end", idx), bus.busy, 1'b0);
         last_rdata = v.exp_rdata;
         @(posedge clk); #1;
         chk($sformatf("t%0d rvalid_pulse", idx), {bus.r0_rvalid, bus.r1_rvalid}, 2'b00);
      end
      $display("txn %0d: winner r%0d %s addr %0h", idx, v.win, ewe ? "write" : "read", eaddr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", bus.busy, 1'b0);
      chk("rst rdata", bus.rdata, 32'h0);
      last_rdata = 32'h0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      vecs[0] = mk(1, 0, 1, 0, 32'h10, 32'h0,  32'hDEADBEEF, 32'h0,        0, 32'h0);
      vecs[1] = mk(0, 1, 0, 0, 32'h0,  32'h10, 32'h0,        32'h0,        1, 32'hDEADBEEF);
      vecs[2] = mk(1, 1, 1, 1, 32'h20, 32'h21, 32'h11111111, 32'h22222222, 0, 32'h0);
      vecs[3] = mk(1, 1, 0, 0, 32'h21, 32'h20, 32'h0,        32'h0,        1, 32'h11111111);
      vecs[4] = mk(1, 1, 0, 0, 32'h21, 32'h10, 32'h0,        32'h0,        0, 32'hA5000021);
      vecs[5] = mk(0, 1, 0, 1, 32'h0,  32'h30, 32'h0,        32'hCAFEF00D, 1, 32'h0);
      vecs[6] = mk(1, 0, 0, 0, 32'h30, 32'h0,  32'h0,        32'h0,        0, 32'hCAFEF00D);
      vecs[7] = mk(1, 1, 0, 1, 32'h10, 32'h31, 32'h0,        32'h12345678, 1, 32'h0);
      vecs[8] = mk(0, 1, 0, 0, 32'h0,  32'h31, 32'h0,        32'h0,        1, 32'h12345678);

      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("reset ctrl", {bus.mem_en, bus.mem_we, bus.r0_gnt, bus.r1_gnt,
                         bus.r0_rvalid, bus.r1_rvalid, bus.busy}, 7'b0);
      chk("reset rdata", bus.rdata, 32'h0);
      chk("reset mem_addr", bus.mem_addr, 32'h0);
      chk("reset mem_wdata", bus.mem_wdata, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

      // r1 requests while r0's read is in flight: it must wait for the IDLE cycle.
      @(negedge clk);
      bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 32'h21;
      @(posedge clk); #1;
      chk("busy_ign gnt0", bus.r0_gnt, 1'b1);
      @(negedge clk);
      bus.r0_req = 1'b0; bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 32'h10;
      @(posedge clk); #1;
      chk("busy_ign gnt1 resp", bus.r1_gnt, 1'b0);
      @(posedge clk); #1;
      chk("busy_ign gnt1 idle", bus.r1_gnt, 1'b0);
      chk("busy_ign rvalid0", bus.r0_rvalid, 1'b1);
      chk("busy_ign rdata0", bus.rdata, 32'hA5000021);
      @(posedge clk); #1;
      chk("busy_ign gnt1 late", bus.r1_gnt, 1'b1);
      @(negedge clk);
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("busy_ign rvalid1", bus.r1_rvalid, 1'b1);
      chk("busy_ign rdata1", bus.rdata, 32'hDEADBEEF);
      $display("txn busy-ignore: r0 read then r1 read");

      // Reset lands while the read is in RESP.
      @(negedge clk);
      bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 32'h20;
      @(posedge clk); #1;
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      chk("midrst in_resp", bus.busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("midrst ctrl", {bus.mem_en, bus.mem_we, bus.r0_gnt, bus.r1_gnt,
                          bus.r0_rvalid, bus.r1_rvalid, bus.busy}, 7'b0);
      chk("midrst rdata", bus.rdata, 32'h0);
      chk("midrst mem_addr", bus.mem_addr, 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("midrst no rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b00);
      end
      @(negedge clk);
      rst = 1'b1;
      last_rdata = 32'h0;
      $display("txn reset-mid-read: dropped");
      run_txn(mk(1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h0, 0, 32'h11111111), 100);

      // Continuous tie from reset: r0, r1, r0, r1, one grant every three cycles.
      do_reset();
      bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 32'h20;
      bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 32'h30;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk($sformatf("tie c%0d gnt0", k), bus.r0_gnt, (k % 6) == 1);
         chk($sformatf("tie c%0d gnt1", k), bus.r1_gnt, (k % 6) == 4);
         chk($sformatf("tie c%0d rvalid0", k), bus.r0_rvalid, (k % 6) == 3);
         chk($sformatf("tie c%0d rvalid1", k), bus.r1_rvalid, (k % 6) == 0);
         if ((k % 6) == 3) chk($sformatf("tie c%0d rdata", k), bus.rdata, 32'h11111111);
         if ((k % 6) == 0) chk($sformatf("tie c%0d rdata", k), bus.rdata, 32'hCAFEF00D);
      end
      @(negedge clk);
      idle_inputs();
      $display("txn tie: four alternating reads");
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits of all address ports.
REQ-002 Parameter DW, default 32, data width in bits of all data ports.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 r0_req, r1_req  input  1 each  access request from requester 0 (core load/store path) and requester 1 (program loader).
REQ-006 r0_we, r1_we  input  1 each  1 = write, 0 = read.
REQ-007 r0_addr, r1_addr  input  AW each  word address.
REQ-008 r0_wdata, r1_wdata  input  DW each  write data.
REQ-009 r0_gnt, r1_gnt  output  1 each  one-cycle pulse: request accepted and memory access performed this cycle.
REQ-010 r0_rvalid, r1_rvalid  output  1 each  one-cycle pulse: read data valid on rdata.
REQ-011 rdata  output  DW  read data, shared by both requesters.
REQ-012 mem_en, mem_we  output  1 each  memory enable and write enable.
REQ-013 mem_addr, mem_wdata  output  AW, DW  memory address and write data.
REQ-014 mem_rdata  input  DW  synchronous-read memory data, valid the cycle after a read with mem_en=1.
REQ-015 busy  output  1  1 whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-017 In IDLE with no request the FSM SHALL stay in IDLE.
REQ-018 In IDLE with any request the FSM SHALL register winner id, we, addr and wdata at the clock edge and move to ACCESS.
REQ-019 Arbitration SHALL work as follows: one requester asserted -> it wins; both asserted -> the requester not granted last wins (round-robin).
REQ-020 The last-granted register SHALL update to the winner at the IDLE->ACCESS edge.
REQ-021 In ACCESS the block SHALL drive mem_en=1, mem_we=captured we, mem_addr=captured addr, mem_wdata=captured wdata, and the winner's gnt=1, for exactly one cycle.
REQ-022 From ACCESS the FSM SHALL go to IDLE on a write and to RESP on a read.
REQ-023 On the RESP->IDLE edge the block SHALL load rdata from mem_rdata; the winner's rvalid SHALL pulse for exactly the following cycle.
REQ-024 rdata SHALL hold its value until the next read completes.
REQ-025 Latency: request sampled in IDLE at edge N -> mem access and gnt in cycle N+1 -> rdata/rvalid in cycle N+3 for reads; a write occupies 2 cycles, a read 3.
REQ-026 Outside ACCESS, mem_en, mem_we and both gnt SHALL be 0; mem_addr and mem_wdata SHALL be don't-care but stable (captured values).
REQ-027 Requesters SHALL hold req, we, addr and wdata stable until their gnt; the block samples inputs only in IDLE.
REQ-028 Deasserting req after capture SHALL NOT cancel the transaction; it completes normally.
REQ-029 Requests arriving while busy SHALL be ignored until the next IDLE cycle and then arbitrated normally.
REQ-030 At most one gnt and at most one rvalid SHALL be high in any cycle.
REQ-031 Requester 1 SHALL be granted the next access after a requester 0 grant while requester 1 requests continuously, and vice versa (no starvation).

Reset
REQ-032 While rst=0, state SHALL be IDLE and mem_en, mem_we, all gnt, all rvalid and busy SHALL be 0 immediately (asynchronously).
REQ-033 While rst=0, rdata, mem_addr, mem_wdata and captured registers SHALL be 0, and last-granted SHALL be 1 so requester 0 wins the first tie.
REQ-034 Reset asserted mid-transaction SHALL drop it: no gnt, no rvalid, and no write unless the ACCESS cycle completed before reset.
REQ-035 After rst returns to 1, the first request SHALL be sampled at the next rising edge.

Verification
REQ-036 Single write: r0 write addr 0x10, data 0xDEADBEEF -> mem_en=mem_we=1 with those values and r0_gnt for one cycle, then IDLE; busy high 1 cycle.
REQ-037 Single read: r1 read addr 0x10, memory returns 0xDEADBEEF -> r1_gnt in cycle N+1, r1_rvalid with rdata=0xDEADBEEF in cycle N+3, r0 outputs stay 0.
REQ-038 Tie after reset: r0 and r1 both request reads continuously -> grants alternate r0, r1, r0, r1, one grant every 3 cycles.
REQ-039 Busy ignore: r1 raises req during an r0 read in ACCESS -> r1 is not granted until the IDLE cycle after r0_rvalid.
REQ-040 Reset mid-read: rst=0 in RESP -> rvalid never pulses, all outputs 0, rdata=0; after rst=1 a fresh r0 read completes normally.
REQ-041 Request withdrawal: r0 drops req the cycle after capture -> r0_gnt and r0_rvalid still occur with the correct data.
